// File: rtl/alu_result_stage.sv
// Result stage behind the ALU: waits a per-class settle time, then captures the
// 64-bit result into Z and, for mul/div, into the architectural HI/LO pair.
module alu_result_stage #(
    parameter int unsigned MUL_WAIT   = 4,
    parameter int unsigned DIV_WAIT   = 16,
    parameter int unsigned BASIC_WAIT = 0
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [4:0]  opcode,
    input  logic        inc_pc,
    input  logic [63:0] c_in,
    output logic [31:0] z_hi,
    output logic [31:0] z_lo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    localparam int unsigned MAX_MD   = (MUL_WAIT > DIV_WAIT) ? MUL_WAIT : DIV_WAIT;
    localparam int unsigned MAX_WAIT = (MAX_MD > BASIC_WAIT) ? MAX_MD : BASIC_WAIT;
    localparam int unsigned CNT_W    = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_BASIC = 3'd0,
        OP_INC   = 3'd1,
        OP_MUL   = 3'd2,
        OP_DIV   = 3'd3,
        OP_MFHI  = 3'd4,
        OP_MFLO  = 3'd5
    } op_t;

    // inc_pc takes priority over whatever the opcode field holds
    function automatic op_t decode_op(input logic inc, input logic [4:0] opc);
        op_t cls;
        if (inc) begin
            cls = OP_INC;
        end else begin
            case (opc)
                5'b01111: cls = OP_MUL;
                5'b10000: cls = OP_DIV;
                5'b11000: cls = OP_MFHI;
                5'b11001: cls = OP_MFLO;
                default:  cls = OP_BASIC;
            endcase
        end
        return cls;
    endfunction

    function automatic logic [CNT_W-1:0] wait_of(input op_t cls);
        logic [CNT_W-1:0] w;
        case (cls)
            OP_MUL:  w = CNT_W'(MUL_WAIT);
            OP_DIV:  w = CNT_W'(DIV_WAIT);
            default: w = CNT_W'(BASIC_WAIT);
        endcase
        return w;
    endfunction

    state_t           state_r, state_nxt_s;
    op_t              op_r, op_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             capture_s;
    logic [31:0]      z_hi_r, z_lo_r, hi_r, lo_r;
    logic             busy_r, done_r;

    // Next-state, settle counter and capture strobe
    always_comb begin
        state_nxt_s = state_r;
        op_nxt_s    = op_r;
        cnt_nxt_s   = cnt_r;
        capture_s   = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    op_nxt_s    = decode_op(inc_pc, opcode);
                    cnt_nxt_s   = wait_of(decode_op(inc_pc, opcode));
                    state_nxt_s = ST_SETTLE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_r != '0) begin
                    cnt_nxt_s = cnt_r - CNT_W'(1'b1);
                end else begin
                    capture_s   = 1'b1;
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Control state; busy/done are registered copies of the next state
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_r <= ST_IDLE;
            op_r    <= OP_BASIC;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            op_r    <= op_nxt_s;
            cnt_r   <= cnt_nxt_s;
            busy_r  <= (state_nxt_s == ST_SETTLE);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // Result capture into Z and HI/LO
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            z_hi_r <= 32'd0;
            z_lo_r <= 32'd0;
            hi_r   <= 32'd0;
            lo_r   <= 32'd0;
        end else if (capture_s) begin
            case (op_r)
                OP_MFHI: begin
                    z_hi_r <= 32'd0;
                    z_lo_r <= hi_r;
                end
                OP_MFLO: begin
                    z_hi_r <= 32'd0;
                    z_lo_r <= lo_r;
                end
                OP_MUL, OP_DIV: begin
                    z_hi_r <= c_in[63:32];
                    z_lo_r <= c_in[31:0];
                    hi_r   <= c_in[63:32];
                    lo_r   <= c_in[31:0];
                end
                default: begin
                    z_hi_r <= c_in[63:32];
                    z_lo_r <= c_in[31:0];
                end
            endcase
        end else begin
            z_hi_r <= z_hi_r;
            z_lo_r <= z_lo_r;
            hi_r   <= hi_r;
            lo_r   <= lo_r;
        end
    end

    assign z_hi = z_hi_r;
    assign z_lo = z_lo_r;
    assign hi   = hi_r;
    assign lo   = lo_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Downstream stage of the ALU. Captures the 64-bit ALU result into the Z pair (z_hi/z_lo) once the combinational path has settled.
- Owns the architectural HI/LO registers, which are written by mul/div and read by mfhi/mflo.
- Settling time is a programmable cycle count per operation class, so the slow combinational mul/div paths are covered without retiming the ALU.
- Sits between the ALU output and the bus drivers for Zhi/Zlo; controlled by the control unit via a start/done handshake.

Parameters:
- MUL_WAIT, 4, extra settle cycles before capture for opcode 01111 (mul).
- DIV_WAIT, 16, extra settle cycles before capture for opcode 10000 (div).
- BASIC_WAIT, 0, extra settle cycles for every other opcode and for inc_pc.

Ports:
- clock  in  1  system clock; all state on rising edge.
- clear  in  1  asynchronous, active-low reset.
- start  in  1  request a capture; sampled on rising edge.
- opcode  in  5  ALU opcode for this operation; sampled only at accepted start.
- inc_pc  in  1  PC-increment operation; sampled only at accepted start; overrides opcode.
- c_in  in  64  ALU result; sampled only at the capture edge.
- z_hi  out  32  captured upper result word.
- z_lo  out  32  captured lower result word.
- hi  out  32  HI register.
- lo  out  32  LO register.
- busy  out  1  high while in SETTLE.
- done  out  1  one-cycle pulse; Z (and HI/LO if written) valid.

Behaviour:
- Reset (clear=0, async): z_hi=z_lo=hi=lo=0, busy=0, done=0, state=IDLE, counter=0, latched op=0. Asserting clear mid-operation aborts immediately; no done pulse; outputs zeroed.
- States: IDLE, SETTLE, DONE. busy=1 only in SETTLE; done=1 only in DONE.
- IDLE or DONE, start=1 at edge E0:
  - Latch op class: INC if inc_pc=1; else MUL (01111), DIV (10000), MFHI (11000), MFLO (11001), otherwise BASIC.
  - Load counter with the class wait: MUL_WAIT, DIV_WAIT, or BASIC_WAIT (INC/MFHI/MFLO use BASIC_WAIT).
  - Go to SETTLE.
- IDLE or DONE, start=0: go/stay IDLE.
- SETTLE:
  - counter != 0: decrement, stay.
  - counter == 0: capture at this edge, go DONE.
- start while in SETTLE is ignored and not queued.
- Latency: with wait W, capture occurs at edge E(W+1); done and the new Z are visible for the cycle after E(W+1). DONE lasts exactly one cycle. A start in DONE makes that cycle's edge the new E0 (back-to-back, no bubble).
- Capture actions:
  - BASIC/INC: z_hi<=c_in[63:32], z_lo<=c_in[31:0]; HI/LO unchanged.
  - MUL/DIV: same Z capture; additionally hi<=c_in[63:32], lo<=c_in[31:0].
  - MFHI: z_lo<=hi, z_hi<=0; c_in ignored.
  - MFLO: z_lo<=lo, z_hi<=0; c_in ignored.
- Z, HI and LO hold their values between captures.
- Upstream holds c_in stable from E0 to E(W+1); opcode/inc_pc changes after E0 have no effect.
- Counter width is sized from the maximum of the three parameters; a wait of 0 is legal.

Test Plan:
- Reset mid-op: start a DIV, assert clear at E5 -> immediate z=0, hi=lo=0, busy=0, no done pulse; after release, state IDLE.
- BASIC add: opcode 00011, c_in=64'h0000_0000_0000_0007, start at E0 -> busy high E0..E1, done high after E1, z_lo=7, z_hi=0, hi/lo unchanged (0).
- MUL (MUL_WAIT=4): c_in=64'h0000_0001_8000_0000 -> done after E5 only; z_hi=1, z_lo=32'h8000_0000, hi=1, lo=32'h8000_0000. Changing c_in at E3 to garbage and back before E5 has no effect.
- DIV then MFHI/MFLO: div c_in=64'h0000_0003_0000_0005 -> hi=3, lo=5 after E17. Next MFHI with c_in=all ones -> z_lo=3, z_hi=0. Then MFLO -> z_lo=5.
- Back-to-back and ignored start: start held high for BASIC ops -> done every 2nd cycle. A start pulse during a DIV SETTLE -> ignored; exactly one done.
- inc_pc=1 with opcode=01111, c_in=64'h0000_0000_0000_0011 -> BASIC latency; z_lo=32'h11; hi/lo not written.
